pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Sequences the decode/operand-fetch (DOF) stage of the 5-stage MIPS pipe.
//  Detects load-use hazards that the EXE->DOF forward path cannot cover,
//  squashes wrong-path instructions after taken branches, and freezes the
//  pipe during multi-cycle memory accesses. Outputs drive PC/IF-DOF holds
//  and the DOF flush input (flush=0 kills RW/MW/BS of the decoded instr).
// PARAMETERS
//  REG_ADDR_BITS      5   register address width (AA/BA/DA)
//  LOAD_STALL_CYCLES  2   bubbles per load-use hazard (>=1)
//  BRANCH_FLUSH_CYCLES 2  cycles of squash after a taken branch (>=1)
//  MEM_TIMEOUT        255 max MWAIT cycles before abort (>=1)
//  PERF_BITS          16  width of stall_count
// PORTS
//  clk          in  1   clock, rising edge
//  rst          in  1   synchronous reset, active-high
//  AA, BA       in  RAB source addresses of instruction in DOF
//  MA, MB       in  1   1 = operand from PC / constant (no reg read)
//  RW_EXE       in  1   EXE instruction writes a register
//  DA_EXE       in  RAB EXE destination register
//  MD_EXE       in  2   EXE result source; 2'b01 = memory load
//  branch_taken in  1   EXE resolved a taken branch/jump this cycle
//  mem_req      in  1   memory stage has an access in flight
//  mem_ready    in  1   memory access completes this cycle
//  pc_hold      out 1   1 = PC keeps its value
//  ifid_hold    out 1   1 = IF/DOF register keeps its value
//  flush        out 1   0 = DOF inserts a bubble (to DOF flush input)
//  pipe_freeze  out 1   1 = EXE and later stage registers hold
//  mem_error    out 1   1-cycle pulse on memory timeout
//  ctl_state    out 2   0 RUN, 1 LSTALL, 2 BFLUSH, 3 MWAIT
//  stall_count  out PERF_BITS  saturating count of cycles with pc_hold=1
// BEHAVIOUR
//  Reset (rst=1 at edge): state RUN, counters 0, mem_error 0, stall_count 0.
//   Output values after reset: pc_hold 0, ifid_hold 0, flush 1,
//   pipe_freeze 0. Reset in any state returns to RUN on the next edge.
//  load_use = RW_EXE & MD_EXE==2'b01 & DA_EXE!=0 &
//   ((AA==DA_EXE & ~MA) | (BA==DA_EXE & ~MB)).
//  Outputs are Mealy in RUN and take effect in the detection cycle.
//  RUN priority: mem_req&~mem_ready > branch_taken > load_use > none.
//   mem wait : pipe_freeze=pc_hold=ifid_hold=1, flush=1; ->MWAIT, cnt=1.
//   branch   : flush=0, pc_hold=0 (PC loads target); remaining squash
//              cycles = BRANCH_FLUSH_CYCLES-1; ->BFLUSH if >0, else RUN.
//   load_use : pc_hold=ifid_hold=1, flush=0; ->LSTALL if
//              LOAD_STALL_CYCLES>1 (cnt=LOAD_STALL_CYCLES-1), else RUN.
//   none     : holds 0, flush 1.
//  LSTALL: pc_hold=ifid_hold=1, flush=0. Decrement cnt; ->RUN after the
//   cycle in which cnt==1. branch_taken in LSTALL: behave as RUN branch.
//  BFLUSH: flush=0, holds 0, load_use ignored. ->RUN after last cycle.
//  MWAIT: pipe_freeze=pc_hold=ifid_hold=1, flush=1. mem_ready=1 -> RUN in
//   the same cycle (holds drop next cycle). cnt==MEM_TIMEOUT with no
//   mem_ready -> mem_error=1 for one cycle, ->RUN.
//  branch_taken is held stable by the freeze and is re-evaluated in RUN.
//  stall_count +1 on every cycle with pc_hold=1; saturates at all-ones.
//  DA_EXE==0 never causes a hazard (r0 is hard-wired).
// TESTING
//  1 rst=1 two edges in MWAIT -> ctl_state=0, holds 0, flush=1, count 0.
//  2 RUN, load to r3 in EXE, AA=3,MA=0 -> 2 cycles pc_hold=1,flush=0, then
//    RUN; repeat with MA=1 -> no stall.
//  3 branch_taken=1 together with load_use -> flush=0 2 cycles, pc_hold=0.
//  4 mem_req=1, mem_ready low 4 cycles then high -> pipe_freeze high exactly
//    5 cycles, stall_count +=5.
//  5 MEM_TIMEOUT=3, mem_ready never set -> mem_error pulse in 3rd MWAIT cyc.
//  6 DA_EXE=0 load, AA=0 -> no stall; stall_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard/stall sequencer for the DOF stage of the 5-stage MIPS pipe.
// Handles load-use bubbles, taken-branch squash and memory-wait freeze.
module pipeline_hazard_controller #(
    parameter int REG_ADDR_BITS       = 5,
    parameter int LOAD_STALL_CYCLES   = 2,
    parameter int BRANCH_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT         = 255,
    parameter int PERF_BITS           = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_ADDR_BITS-1:0] AA,
    input  logic [REG_ADDR_BITS-1:0] BA,
    input  logic                     MA,
    input  logic                     MB,
    input  logic                     RW_EXE,
    input  logic [REG_ADDR_BITS-1:0] DA_EXE,
    input  logic [1:0]               MD_EXE,
    input  logic                     branch_taken,
    input  logic                     mem_req,
    input  logic                     mem_ready,
    output logic                     pc_hold,
    output logic                     ifid_hold,
    output logic                     flush,
    output logic                     pipe_freeze,
    output logic                     mem_error,
    output logic [1:0]               ctl_state,
    output logic [PERF_BITS-1:0]     stall_count
);

    localparam int CNT_MAX_A = (LOAD_STALL_CYCLES > BRANCH_FLUSH_CYCLES) ?
                               LOAD_STALL_CYCLES : BRANCH_FLUSH_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > MEM_TIMEOUT) ? CNT_MAX_A : MEM_TIMEOUT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LSTALL_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BFLUSH_INIT = CNT_W'(BRANCH_FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEM_LIMIT   = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        BFLUSH = 2'd2,
        MWAIT  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [PERF_BITS-1:0] r_stall_count;

    logic w_load_use;
    logic w_mem_wait;
    logic w_pc_hold;
    logic w_ifid_hold;
    logic w_flush;
    logic w_freeze;
    logic w_mem_error;

    assign w_mem_wait = mem_req & ~mem_ready;
    assign w_load_use = RW_EXE & (MD_EXE == 2'b01) & (DA_EXE != '0) &
                        (((AA == DA_EXE) & ~MA) | ((BA == DA_EXE) & ~MB));

    // Outputs are Mealy so a hazard takes effect in its detection cycle;
    // only state, counter and the perf count are registered.
    always_comb begin
        w_pc_hold   = 1'b0;
        w_ifid_hold = 1'b0;
        w_flush     = 1'b1;
        w_freeze    = 1'b0;
        w_mem_error = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RUN: begin
                if (w_mem_wait) begin
                    w_pc_hold   = 1'b1;
                    w_ifid_hold = 1'b1;
                    w_freeze    = 1'b1;
                    w_state_nxt = MWAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else if (branch_taken) begin
                    w_flush     = 1'b0;
                    w_state_nxt = (BRANCH_FLUSH_CYCLES > 1) ? BFLUSH : RUN;
                    w_cnt_nxt   = BFLUSH_INIT;
                end else if (w_load_use) begin
                    w_pc_hold   = 1'b1;
                    w_ifid_hold = 1'b1;
                    w_flush     = 1'b0;
                    w_state_nxt = (LOAD_STALL_CYCLES > 1) ? LSTALL : RUN;
                    w_cnt_nxt   = LSTALL_INIT;
                end
            end
            LSTALL: begin
                w_flush = 1'b0;
                if (branch_taken) begin
                    w_state_nxt = (BRANCH_FLUSH_CYCLES > 1) ? BFLUSH : RUN;
                    w_cnt_nxt   = BFLUSH_INIT;
                end else begin
                    w_pc_hold   = 1'b1;
                    w_ifid_hold = 1'b1;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                    if (r_cnt <= CNT_ONE) w_state_nxt = RUN;
                end
            end
            BFLUSH: begin
                w_flush   = 1'b0;
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt <= CNT_ONE) w_state_nxt = RUN;
            end
            MWAIT: begin
                w_pc_hold   = 1'b1;
                w_ifid_hold = 1'b1;
                w_freeze    = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = RUN;
                end else if (r_cnt >= MEM_LIMIT) begin
                    w_mem_error = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_cnt         <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_pc_hold && (r_stall_count != '1))
                r_stall_count <= r_stall_count + PERF_BITS'(1);
        end
    end

    assign pc_hold     = w_pc_hold;
    assign ifid_hold   = w_ifid_hold;
    assign flush       = w_flush;
    assign pipe_freeze = w_freeze;
    assign mem_error   = w_mem_error;
    assign ctl_state   = r_state;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: directed vectors push expected outputs, a negedge
// monitor pops and compares. DUT 0 uses defaults, DUT 1 a short timeout/count.
module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] aa, ba, da;
    logic       ma, mb, mr;
    logic [1:0] md;
    logic       rw_a, br_a, mq_a, rw_b, br_b, mq_b;

    logic        a_ph, a_ih, a_fl, a_fz, a_me;
    logic [1:0]  a_st;
    logic [15:0] a_sc;
    logic        b_ph, b_ih, b_fl, b_fz, b_me;
    logic [1:0]  b_st;
    logic [3:0]  b_sc;

    pipeline_hazard_controller u_dut_a (
        .clk(clk), .rst(rst), .AA(aa), .BA(ba), .MA(ma), .MB(mb),
        .RW_EXE(rw_a), .DA_EXE(da), .MD_EXE(md), .branch_taken(br_a),
        .mem_req(mq_a), .mem_ready(mr),
        .pc_hold(a_ph), .ifid_hold(a_ih), .flush(a_fl), .pipe_freeze(a_fz),
        .mem_error(a_me), .ctl_state(a_st), .stall_count(a_sc)
    );

    pipeline_hazard_controller #(.MEM_TIMEOUT(3), .PERF_BITS(4)) u_dut_b (
        .clk(clk), .rst(rst), .AA(aa), .BA(ba), .MA(ma), .MB(mb),
        .RW_EXE(rw_b), .DA_EXE(da), .MD_EXE(md), .branch_taken(br_b),
        .mem_req(mq_b), .mem_ready(mr),
        .pc_hold(b_ph), .ifid_hold(b_ih), .flush(b_fl), .pipe_freeze(b_fz),
        .mem_error(b_me), .ctl_state(b_st), .stall_count(b_sc)
    );

    typedef struct {
        int         sel;
        logic [3:0] o;     // {pc_hold, ifid_hold, flush, pipe_freeze}
        logic       me;
        logic [1:0] st;
        int         cnt;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ecnt[2] = '{0, 0};
    int   emax[2] = '{65535, 15};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [3:0] ao;
            logic       ame;
            logic [1:0] ast;
            int         acnt;
            e = q.pop_front();
            if (e.sel == 0) begin
                ao = {a_ph, a_ih, a_fl, a_fz}; ame = a_me; ast = a_st; acnt = int'(a_sc);
            end else begin
                ao = {b_ph, b_ih, b_fl, b_fz}; ame = b_me; ast = b_st; acnt = int'(b_sc);
            end
            n_tests++;
            if (ao !== e.o || ame !== e.me || ast !== e.st || acnt != e.cnt) begin
                n_fail++;
                $display("FAIL %s (dut%0d): got o=%b me=%b st=%0d cnt=%0d, expected o=%b me=%b st=%0d cnt=%0d",
                         e.nm, e.sel, ao, ame, ast, acnt, e.o, e.me, e.st, e.cnt);
            end
        end
    end

    task automatic cyc(input int sel, input logic [4:0] a_i, input logic [4:0] b_i,
                       input logic ma_i, input logic mb_i, input logic rw,
                       input logic [4:0] d_i, input logic [1:0] m_i, input logic br,
                       input logic mq, input logic mrd, input logic [3:0] o,
                       input logic me, input logic [1:0] st, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        aa = a_i; ba = b_i; ma = ma_i; mb = mb_i; da = d_i; md = m_i; mr = mrd;
        rw_a = (sel == 0) & rw; br_a = (sel == 0) & br; mq_a = (sel == 0) & mq;
        rw_b = (sel == 1) & rw; br_b = (sel == 1) & br; mq_b = (sel == 1) & mq;
        e.sel = sel; e.o = o; e.me = me; e.st = st; e.cnt = ecnt[sel]; e.nm = nm;
        q.push_back(e);
        if (o[3] && ecnt[sel] < emax[sel]) ecnt[sel]++;
    endtask

    task automatic idle(input int sel, input string nm);
        cyc(sel, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0,
            4'b0010, 1'b0, 2'd0, nm);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        aa = '0; ba = '0; da = '0; ma = 1'b1; mb = 1'b1; md = '0; mr = 1'b0;
        rw_a = 0; br_a = 0; mq_a = 0; rw_b = 0; br_b = 0; mq_b = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ecnt[0] = 0;
        ecnt[1] = 0;
    endtask

    initial begin
        rst = 1'b1;
        aa = '0; ba = '0; da = '0; ma = 1'b1; mb = 1'b1; md = '0; mr = 1'b0;
        rw_a = 0; br_a = 0; mq_a = 0; rw_b = 0; br_b = 0; mq_b = 0;
        do_reset();
        idle(0, "reset_idle_a");
        idle(1, "reset_idle_b");

        // reset while in MWAIT
        cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 1, 0, 4'b1111, 0, 2'd0, "mw_enter");
        cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 1, 0, 4'b1111, 0, 2'd3, "mw_hold");
        do_reset();
        idle(0, "rst_from_mwait");

        // load-use on A operand, then MA=1, BA operand, ALU result
        cyc(0, 3, 7, 0, 1, 1, 3, 2'b01, 0, 0, 0, 4'b1100, 0, 2'd0, "lu_detect");
        cyc(0, 3, 7, 0, 1, 0, 3, 2'b01, 0, 0, 0, 4'b1100, 0, 2'd1, "lu_lstall");
        idle(0, "lu_back_run");
        cyc(0, 3, 7, 1, 1, 1, 3, 2'b01, 0, 0, 0, 4'b0010, 0, 2'd0, "lu_ma_const");
        cyc(0, 5, 3, 0, 0, 1, 3, 2'b01, 0, 0, 0, 4'b1100, 0, 2'd0, "lu_ba_detect");
        cyc(0, 5, 3, 0, 0, 0, 3, 2'b01, 0, 0, 0, 4'b1100, 0, 2'd1, "lu_ba_lstall");
        cyc(0, 3, 3, 0, 0, 1, 3, 2'b00, 0, 0, 0, 4'b0010, 0, 2'd0, "alu_fwd_nostall");

        // branch beats load-use; branch during LSTALL
        cyc(0, 3, 0, 0, 1, 1, 3, 2'b01, 1, 0, 0, 4'b0000, 0, 2'd0, "br_lu_detect");
        cyc(0, 3, 0, 0, 1, 1, 3, 2'b01, 0, 0, 0, 4'b0000, 0, 2'd2, "br_bflush_ign_lu");
        idle(0, "br_back_run");
        cyc(0, 4, 0, 0, 1, 1, 4, 2'b01, 0, 0, 0, 4'b1100, 0, 2'd0, "lu_then_br");
        cyc(0, 4, 0, 0, 1, 0, 4, 2'b01, 1, 0, 0, 4'b0000, 0, 2'd1, "br_in_lstall");
        cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 4'b0000, 0, 2'd2, "br_lstall_bflush");
        idle(0, "br_lstall_run");

        // memory wait: ready low 4 cycles then high -> 5 freeze cycles
        cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 1, 0, 4'b1111, 0, 2'd0, "mw_c0");
        for (int unsigned i = 0; i < 3; i++)
            cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 1, 0, 4'b1111, 0, 2'd3, "mw_wait");
        cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 1, 1, 4'b1111, 0, 2'd3, "mw_ready");
        idle(0, "mw_back_run");
        cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 1, 1, 4'b0010, 0, 2'd0, "mem_ready_nowait");

        // mem wait beats branch; branch re-evaluated after freeze
        cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 1, 1, 0, 4'b1111, 0, 2'd0, "mw_over_br");
        cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 1, 1, 1, 4'b1111, 0, 2'd3, "mw_br_ready");
        cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 1, 0, 0, 4'b0000, 0, 2'd0, "br_after_mw");
        cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 4'b0000, 0, 2'd2, "br_after_mw_fl");
        idle(0, "br_after_mw_run");

        // r0 destination never hazards
        cyc(0, 0, 0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 4'b0010, 0, 2'd0, "r0_nohazard");

        // timeout on DUT 1 (MEM_TIMEOUT=3)
        cyc(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 1, 0, 4'b1111, 0, 2'd0, "to_enter");
        cyc(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 1, 0, 4'b1111, 0, 2'd3, "to_mw1");
        cyc(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 1, 0, 4'b1111, 0, 2'd3, "to_mw2");
        cyc(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 1, 0, 4'b1111, 1, 2'd3, "to_mw3_error");
        idle(1, "to_back_run");

        // stall_count saturation on DUT 1 (4-bit)
        for (int unsigned i = 0; i < 8; i++) begin
            cyc(1, 6, 0, 0, 1, 1, 6, 2'b01, 0, 0, 0, 4'b1100, 0, 2'd0, "sat_detect");
            cyc(1, 6, 0, 0, 1, 0, 6, 2'b01, 0, 0, 0, 4'b1100, 0, 2'd1, "sat_lstall");
        end
        idle(1, "sat_hold");
        idle(0, "final_a");

        for (int unsigned i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
